// File: rtl/lcd12864_rx.sv
`default_nettype none
// ============================================================================
// Module   : lcd12864_rx
// Brief    : ST7920-style 128x64 LCD bus responder holding a 64-byte DDRAM
//            image with display/cursor state; bus reads with LCD_RX_READ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lcd12864_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_dat_in,
  output logic [7:0] lcd_dat_out,
  output logic       lcd_dat_oe,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [5:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       wr_strobe,
  output logic       err
);

  localparam int                c_BUSY_W    = $clog2(BUSY_CYCLES + 1);
  localparam logic [c_BUSY_W-1:0] c_BUSY_LOAD = c_BUSY_W'(BUSY_CYCLES);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FILL = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [5:0]    r_fill_addr;
  logic [10:0]   r_sync [SYNC_STAGES];
  logic [10:0]   r_prev;
  logic [10:0]   w_s;
  logic          w_fall;
  logic          w_rise;
  logic          r_commit;
  logic          r_c_rs;
  logic          r_c_rw;
  logic [7:0]    r_c_dat;
  logic          r_inc;
  logic          r_re;
  logic [c_BUSY_W-1:0] r_busy_cnt;
  logic          w_wr;
  logic          w_drop;
  logic          w_dwr;
  logic          w_iwr;
  logic          w_drd;
  logic          w_clear;
  logic [5:0]    w_ac_step;
  logic [7:0]    mem [64];

  // Bus sample word: {en, rs, rw, dat}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_dat_in};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_fall = r_prev[10] & ~w_s[10];
  assign w_rise = w_s[10] & ~r_prev[10];

  // RS/RW/data come from the last sample that still had en high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_commit <= 1'b0;
      r_c_rs   <= 1'b0;
      r_c_rw   <= 1'b0;
      r_c_dat  <= '0;
    end else begin
      r_commit <= w_fall;
      if (w_fall) begin
        r_c_rs  <= r_prev[9];
        r_c_rw  <= r_prev[8];
        r_c_dat <= r_prev[7:0];
      end
    end
  end

  assign busy      = (r_state == ST_FILL) || (r_busy_cnt != '0);
  assign w_wr      = r_commit & ~r_c_rw;
  assign w_drop    = w_wr & busy;
  assign w_dwr     = w_wr & ~busy & r_c_rs;
  assign w_iwr     = w_wr & ~busy & ~r_c_rs;
  assign w_clear   = w_iwr & ~r_re & (r_c_dat == 8'h01);
  assign wr_strobe = w_dwr;
  assign w_ac_step = r_inc ? ac + 6'd1 : ac - 6'd1;

`ifdef LCD_RX_READ_EN
  logic [7:0] r_dout;
  logic [7:0] w_fresh;

  assign w_drd   = r_commit & r_c_rw & r_c_rs;
  assign w_fresh = w_s[9] ? mem[ac] : {busy, 1'b0, ac};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_dout <= '0;
    else if (w_rise && w_s[8]) r_dout <= w_fresh;
  end

  assign lcd_dat_out = (w_rise && w_s[8]) ? w_fresh : r_dout;
  assign lcd_dat_oe  = (w_s[10] & w_s[8]) | (r_prev[10] & r_prev[8]) | (r_commit & r_c_rw);
`else
  assign w_drd       = 1'b0;
  assign lcd_dat_out = 8'h00;
  assign lcd_dat_oe  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_fill_addr <= '0;
    end else begin
      r_state     <= w_state_n;
      r_fill_addr <= (r_state == ST_FILL) ? r_fill_addr + 6'd1 : 6'd0;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_FILL: if (r_fill_addr == 6'd63) w_state_n = ST_RUN;
      ST_RUN:  if (w_clear)              w_state_n = ST_FILL;
      default: w_state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac         <= '0;
      r_inc      <= 1'b1;
      r_re       <= 1'b0;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      err        <= 1'b0;
      r_busy_cnt <= '0;
    end else begin
      if (w_drop) err <= 1'b1;
      if (r_busy_cnt != '0) r_busy_cnt <= r_busy_cnt - c_BUSY_W'(1);
      if (w_wr && !busy && !w_clear) r_busy_cnt <= c_BUSY_LOAD;
      if (w_dwr || w_drd) ac <= w_ac_step;
      // Function set wins; extended mode masks the rest of the basic set.
      if (w_iwr) begin
        if (r_c_dat[7:5] == 3'b001) begin
          r_re <= r_c_dat[2];
        end else if (!r_re) begin
          if (r_c_dat[7])                        ac <= {r_c_dat[4:0], 1'b0};
          else if (r_c_dat[7:3] == 5'b00001)     {disp_on, cursor_on, blink_on} <= r_c_dat[2:0];
          else if (r_c_dat[7:2] == 6'b000001)    r_inc <= r_c_dat[1];
          else if (r_c_dat[7:1] == 7'b0000001)   ac <= '0;
          else if (r_c_dat == 8'h01) begin
            ac    <= '0;
            r_inc <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_FILL) mem[r_fill_addr] <= 8'h20;
    else if (w_dwr)         mem[ac]          <= r_c_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd12864_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd12864_rx
// Brief    : Scoreboard bench for lcd12864_rx; write-strobe addresses and
//            local-port reads are queued and checked by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd12864_rx;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic [7:0] lcd_dat_in = 8'h00;
  logic [7:0] lcd_dat_out;
  logic       lcd_dat_oe;
  logic [5:0] rd_addr = 6'd0;
  logic [7:0] rd_data;
  logic [5:0] ac;
  logic       disp_on, cursor_on, blink_on, busy, wr_strobe, err;

  always #5 clk = ~clk;

  lcd12864_rx #(.SYNC_STAGES(SYNC), .BUSY_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_dat_in(lcd_dat_in), .lcd_dat_out(lcd_dat_out), .lcd_dat_oe(lcd_dat_oe),
    .rd_addr(rd_addr), .rd_data(rd_data), .ac(ac), .disp_on(disp_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .busy(busy),
    .wr_strobe(wr_strobe), .err(err)
  );

  int n_pass = 0;
  int n_fail = 0;
  int strobes = 0;
  int exp_wr_q[$];
  int exp_rd_q[$];
  logic rd_req = 1'b0;
  logic rd_v = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_v <= rd_req;

  // Monitor: consumes expectations whenever the DUT presents a strobe or read
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobes++;
      if (exp_wr_q.size() == 0) check("unexpected_wr_strobe", 1, 0);
      else check("wr_strobe_addr", int'(ac), exp_wr_q.pop_front());
    end
    if (rd_v) begin
      if (exp_rd_q.size() == 0) check("unexpected_rd", 1, 0);
      else check("rd_data", int'(rd_data), exp_rd_q.pop_front());
    end
  end

  task automatic bus_write(input logic rs, input logic [7:0] d);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_dat_in = d; lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) check("busy_timeout", 1, 0);
  endtask

  task automatic cmd(input logic [7:0] d);
    bus_write(1'b0, d);
    wait_idle();
  endtask

  task automatic wr_data(input logic [7:0] d, input int addr);
    exp_wr_q.push_back(addr);
    bus_write(1'b1, d);
    wait_idle();
  endtask

  task automatic rd_chk(input int a, input int exp);
    rd_addr = 6'(a);
    exp_rd_q.push_back(exp);
    rd_req = 1'b1;
    @(negedge clk);
  endtask

  task automatic rd_done();
    rd_req = 1'b0;
    @(negedge clk);
  endtask

`ifdef LCD_RX_READ_EN
  task automatic bus_read(input logic rs, input int exp, input string name);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    check({name, "_oe"}, int'(lcd_dat_oe), 1);
    check(name, int'(lcd_dat_out), exp);
    lcd_en = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    check({name, "_oe_off"}, int'(lcd_dat_oe), 0);
    lcd_rw = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] hello [5];
    logic [7:0] scr [16];
    int n;
    int s0;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    scr = '{8'h4C, 8'h43, 8'h44, 8'h31, 8'h32, 8'h38, 8'h78, 8'h36,
            8'h34, 8'h20, 8'h73, 8'h63, 8'h72, 8'h65, 8'h65, 8'h6E};

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 1);
    check("rst_ac", int'(ac), 0);
    check("rst_strobe", int'(wr_strobe), 0);
    check("rst_err", int'(err), 0);
    check("rst_disp", int'({disp_on, cursor_on, blink_on}), 0);
    check("rst_oe", int'(lcd_dat_oe), 0);
    check("rst_dout", int'(lcd_dat_out), 0);
    check("rst_rd_data", int'(rd_data), 0);

    // Abort a fill part-way, then time the restarted fill
    rst = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_fill_busy", int'(busy), 1);
    rst = 1'b0;
    n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    check("fill_length", n, 64);
    @(negedge clk);
    for (int a = 0; a < 64; a++) rd_chk(a, 8'h20);
    rd_done();
    check("fill_ac", int'(ac), 0);

    // Init sequence and "Hello"
    cmd(8'h30); cmd(8'h0C); cmd(8'h06);
    bus_write(1'b0, 8'h01);
    check("clear_busy", int'(busy), 1);
    wait_idle();
    check("disp_on", int'(disp_on), 1);
    check("cursor_on", int'(cursor_on), 0);
    check("blink_on", int'(blink_on), 0);
    s0 = strobes;
    for (int i = 0; i < 5; i++) wr_data(hello[i], i);
    check("hello_ac", int'(ac), 5);
    check("hello_strobes", strobes - s0, 5);
    for (int i = 0; i < 5; i++) rd_chk(i, hello[i]);
    rd_chk(5, 8'h20);
    rd_done();

    // Row 1 starts at byte 32
    cmd(8'h90);
    check("row1_ac", int'(ac), 32);
    for (int i = 0; i < 16; i++) wr_data(scr[i], 32 + i);
    check("row1_end_ac", int'(ac), 48);
    for (int i = 0; i < 16; i++) rd_chk(32 + i, scr[i]);
    rd_chk(16, 8'h20);
    rd_done();

    // Decrement wraps 0 -> 63
    cmd(8'h04); cmd(8'h80);
    wr_data(8'h41, 0);
    wr_data(8'h42, 63);
    check("dec_ac", int'(ac), 62);
    rd_chk(0, 8'h41); rd_chk(63, 8'h42);
    rd_done();

    // Data write lands while the previous command keeps busy high
    bus_write(1'b0, 8'h0C);
    bus_write(1'b1, 8'h55);
    wait_idle();
    check("err_set", int'(err), 1);
    check("drop_ac", int'(ac), 62);
    rd_chk(62, 8'h20);
    rd_done();

    // Extended mode masks clear and home
    cmd(8'h34);
    bus_write(1'b0, 8'h01);
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    check("re_clear_short_busy", int'(n < 16), 1);
    check("re_clear_ac", int'(ac), 62);
    cmd(8'h02);
    check("re_home_ignored", int'(ac), 62);
    rd_chk(0, 8'h41);
    rd_done();
    cmd(8'h30);
    cmd(8'h02);
    check("home_ac", int'(ac), 0);
    check("err_sticky", int'(err), 1);

`ifdef LCD_RX_READ_EN
    bus_read(1'b0, 8'h00, "rd_status");
    cmd(8'h88);
    bus_read(1'b1, 8'h20, "rd_data16");
    check("rd_ac_adv", int'(ac), 17);
    cmd(8'h90);
    bus_read(1'b1, 8'h4C, "rd_data32");
    check("rd_ac_adv2", int'(ac), 33);
    lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rd_mid_oe", int'(lcd_dat_oe), 1);
    rst = 1'b1;
    #1;
    check("rd_rst_oe", int'(lcd_dat_oe), 0);
    lcd_en = 1'b0; lcd_rw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_idle();
    check("rd_rst_ac", int'(ac), 0);
`else
    lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    check("noread_oe", int'(lcd_dat_oe), 0);
    lcd_en = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    lcd_rw = 1'b0;
    check("noread_ac", int'(ac), 0);
    check("noread_busy", int'(busy), 0);
    check("noread_dout", int'(lcd_dat_out), 0);
`endif

    repeat (4) @(negedge clk);
    check("wr_queue_empty", exp_wr_q.size(), 0);
    check("rd_queue_empty", exp_rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
`default_nettype wire
